// File: rtl/dmem_hub_if.sv
// dmem_hub_if: processor-to-hub request/response bus
interface dmem_hub_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    modport master (
        output req_valid, req_wren, req_addr, req_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_wren, req_addr, req_data,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/dmem_hub.sv
// dmem_hub: wait-stated data memory hub with RAM and a cycle counter / GPIO / scratch MMIO window
module dmem_hub #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 2048,
    parameter int WAIT_CYCLES = 2,
    parameter int MMIO_BASE   = 'hFF0,
    parameter int GPIO_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_hub_if.slave         bus,
    output logic [GPIO_W-1:0] gpio_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(MMIO_BASE);
    localparam logic [ADDR_W-1:0] WIN_A = ADDR_W'(16);
    localparam logic [3:0] WAIT_LD = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_d;
    logic [3:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, a, off;
    logic [DATA_W-1:0] data_q, d, rd, cnt, scratch;
    logic wren_q, w, accept, go, in_ram, in_mmio, is_cnt, is_gpio, is_scr, err;
    logic [DATA_W-1:0] mem [DEPTH];
    assign accept = state == IDLE && bus.req_valid;
    // with zero wait states the access commits on the accept edge, before the latches update
    assign a = state == IDLE ? bus.req_addr : addr_q;
    assign d = state == IDLE ? bus.req_data : data_q;
    assign w = state == IDLE ? bus.req_wren : wren_q;
    assign off = a - BASE_A;
    assign in_ram = a < DEPTH_A;
    assign in_mmio = a >= BASE_A && off < WIN_A;
    assign is_cnt = in_mmio && off == '0;
    assign is_gpio = in_mmio && off == ADDR_W'(1);
    assign is_scr = in_mmio && off == ADDR_W'(2);
    assign err = !(in_ram || is_gpio || is_scr || (is_cnt && !w));
    assign rd = in_ram ? mem[a[AW-1:0]] : is_cnt ? cnt : is_gpio ? DATA_W'(gpio_out) : is_scr ? scratch : '0;
    assign go = state_d == RESP && state != RESP;
    assign bus.req_ready = state == IDLE;
    assign bus.resp_valid = state == RESP;
    always_comb begin
        state_d = state;
        wait_d = wait_q;
        case (state)
            IDLE: if (accept) begin
                state_d = WAIT_CYCLES == 0 ? RESP : BUSY;
                wait_d = WAIT_LD;
            end
            BUSY: begin
                state_d = wait_q == '0 ? RESP : BUSY;
                wait_d = wait_q == '0 ? '0 : wait_q - 4'd1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wait_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            wren_q <= 1'b0;
            cnt <= '0;
            gpio_out <= '0;
            scratch <= '0;
            bus.resp_data <= '0;
            bus.resp_err <= 1'b0;
        end else begin
            state <= state_d;
            wait_q <= wait_d;
            cnt <= cnt + 1'b1;
            if (accept) begin
                addr_q <= bus.req_addr;
                data_q <= bus.req_data;
                wren_q <= bus.req_wren;
            end
            if (go) begin
                bus.resp_data <= w || err ? '0 : rd;
                bus.resp_err <= err;
                if (w && is_gpio) gpio_out <= d[GPIO_W-1:0];
                if (w && is_scr) scratch <= d;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (go && w && in_ram) mem[a[AW-1:0]] <= d;
    end
endmodule
